core_boot_sequencer: RTL and testbench

CORE_BOOT_SEQUENCER -- requirements
Module: core_boot_sequencer

---
 rtl/core_boot_pkg.sv | 37 +++
 rtl/sync2.sv | 34 +++
 rtl/core_boot_sequencer.sv | 160 ++++++++++++++++
 tb/tb_core_boot_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_boot_pkg.sv
//============================================================================
// Module      : core_boot_pkg
// Description : Shared definitions for the core boot sequencer. Holds the
//               sequencer state encoding, default timing constants and a
//               helper that sizes the shared cycle counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package core_boot_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        SETTLE     = 3'd1,
        WAIT_LOAD  = 3'd2,
        HOLD_RESET = 3'd3,
        SIGNAL     = 3'd4,
        RUN        = 3'd5
    } boot_state_t;

    localparam int DEF_SETTLE_CYCLES     = 1024;
    localparam int DEF_RESET_HOLD_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES    = 1 << 24;

    // Width able to hold the largest of the three cycle limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
//============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single-bit level crossing into
//               the local clock domain.
// Revision    : 1.0 - initial release
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset (both flops to 0)
//               d    - asynchronous input level
//               q    - synchronized level, two clk cycles of latency
//============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_boot_sequencer.sv
//============================================================================
// Module      : core_boot_sequencer
// Description : Brings a core out of reset once its PLL has been stably
//               locked, its data slots are loaded and a fixed reset hold has
//               elapsed, then handshakes once on the ready-to-run interface.
//               Any loss of lock restarts the whole sequence.
// Revision    : 1.0 - initial release
// Macro       : CORE_BOOT_SEQUENCER_TIMEOUT_EN - enables the data-load
//               watchdog that drives load_timeout.
// Ports       : bridge_clk      - single clock
//               reset           - asynchronous active-high reset
//               pll_core_locked - PLL lock, asynchronous to bridge_clk
//               load_complete   - level, all data slots loaded
//               rtr_valid       - ready-to-run valid level
//               rtr_done        - ready-to-run acknowledge, 1-cycle pulse
//               core_reset_n    - active-low core reset (registered)
//               state           - current FSM encoding for debug
//               load_timeout    - sticky watchdog flag (0 when disabled)
//============================================================================
`default_nettype none

module core_boot_sequencer
    import core_boot_pkg::*;
#(
    parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
    parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic       bridge_clk,
    input  logic       reset,
    input  logic       pll_core_locked,
    input  logic       load_complete,
    input  logic       rtr_valid,
    output logic       rtr_done,
    output logic       core_reset_n,
    output logic [2:0] state,
    output logic       load_timeout
);

    localparam int CW = cnt_width(SETTLE_CYCLES, RESET_HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

    boot_state_t   cur_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          lock_s;
    logic          lock_lost;

    sync2 u_lock_sync (
        .clk (bridge_clk),
        .rst (reset),
        .d   (pll_core_locked),
        .q   (lock_s)
    );

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    assign lock_lost = (cur_state != WAIT_LOCK) && !lock_s;

    always_ff @(posedge bridge_clk or posedge reset) begin
        if (reset) begin
            cur_state    <= WAIT_LOCK;
            cnt          <= '0;
            rtr_done     <= 1'b0;
            core_reset_n <= 1'b0;
        end else begin
            rtr_done <= 1'b0;
            if (lock_lost) begin
                // Lock loss overrides every other transition.
                cur_state    <= WAIT_LOCK;
                cnt          <= '0;
                core_reset_n <= 1'b0;
            end else begin
                case (cur_state)
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            cur_state <= SETTLE;
                            cnt       <= '0;
                        end
                    end
                    SETTLE: begin
                        if (cnt >= SETTLE_LAST) begin
                            cur_state <= WAIT_LOAD;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_LOAD: begin
                        if (load_complete) begin
                            cur_state <= HOLD_RESET;
                            cnt       <= '0;
                        end
                    end
                    HOLD_RESET: begin
                        // core_reset_n rises together with the move to SIGNAL,
                        // so it is low for exactly RESET_HOLD_CYCLES cycles here.
                        if (cnt >= HOLD_LAST) begin
                            cur_state    <= SIGNAL;
                            cnt          <= '0;
                            core_reset_n <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    SIGNAL: begin
                        if (rtr_valid) begin
                            cur_state <= RUN;
                            rtr_done  <= 1'b1;
                        end
                    end
                    RUN: begin
                        cur_state <= RUN;
                    end
                    default: begin
                        cur_state    <= WAIT_LOCK;
                        cnt          <= '0;
                        core_reset_n <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = cur_state;

`ifdef CORE_BOOT_SEQUENCER_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tcnt;
    logic          timeout_flag;

    // Watchdog only observes WAIT_LOAD; it never changes the sequencing.
    always_ff @(posedge bridge_clk or posedge reset) begin
        if (reset) begin
            tcnt         <= '0;
            timeout_flag <= 1'b0;
        end else if (lock_lost) begin
            tcnt         <= '0;
            timeout_flag <= 1'b0;
        end else if (cur_state == WAIT_LOAD) begin
            if (tcnt >= TIMEOUT_LAST) begin
                timeout_flag <= 1'b1;
            end else begin
                tcnt <= tcnt + CW'(1);
            end
        end else begin
            tcnt <= '0;
        end
    end

    assign load_timeout = timeout_flag;
`else
    assign load_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_boot_sequencer.sv
//============================================================================
// Module      : tb_core_boot_sequencer
// Description : Self-checking bench for core_boot_sequencer. A behavioural
//               phase/elapsed-time model tracks what the outputs must be;
//               directed scenarios also check absolute latencies.
// Revision    : 1.0 - initial release
// Macro       : CORE_BOOT_SEQUENCER_TIMEOUT_EN - also exercises the watchdog
//============================================================================
`default_nettype none

module tb_core_boot_sequencer;

    localparam int S = 8;
    localparam int H = 4;
    localparam int T = 20;
    // Edges from a lock rise (or reset release with lock high) until
    // core_reset_n is seen high: 2 sync + 1 leave WAIT_LOCK + S + 1 load + H.
    localparam int SEQ_LAT = S + H + 4;

    localparam int P_WAIT_LOCK  = 0;
    localparam int P_SETTLE     = 1;
    localparam int P_WAIT_LOAD  = 2;
    localparam int P_HOLD_RESET = 3;
    localparam int P_SIGNAL     = 4;
    localparam int P_RUN        = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       pll   = 1'b0;
    logic       load  = 1'b0;
    logic       rv    = 1'b0;
    logic       rtr_done;
    logic       core_reset_n;
    logic [2:0] state;
    logic       load_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: lock seen through a 2-cycle delay, a phase, and the
    // number of cycles already spent in the timed phases.
    bit m_l1, m_l2, m_done, m_to;
    int m_phase, m_spent, m_wl;

    core_boot_sequencer #(
        .SETTLE_CYCLES     (S),
        .RESET_HOLD_CYCLES (H),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .bridge_clk      (clk),
        .reset           (reset),
        .pll_core_locked (pll),
        .load_complete   (load),
        .rtr_valid       (rv),
        .rtr_done        (rtr_done),
        .core_reset_n    (core_reset_n),
        .state           (state),
        .load_timeout    (load_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_l1 = 0; m_l2 = 0; m_done = 0; m_to = 0;
        m_phase = P_WAIT_LOCK; m_spent = 0; m_wl = 0;
    endtask

    function automatic logic [5:0] exp_vec();
        logic rn;
        rn = (m_phase == P_SIGNAL) || (m_phase == P_RUN);
        return {3'(m_phase), rn, m_done, m_to};
    endfunction

    // Advance one clock edge, update the model from the inputs present at
    // that edge, and return 1 time unit after it.
    task automatic tick();
        bit ls;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            ls     = m_l2;
            m_l2   = m_l1;
            m_l1   = pll;
            m_done = 0;
            if (m_phase != P_WAIT_LOCK && !ls) begin
                m_phase = P_WAIT_LOCK; m_spent = 0; m_wl = 0; m_to = 0;
            end else begin
                if (m_phase == P_WAIT_LOAD) begin
                    m_wl++;
`ifdef CORE_BOOT_SEQUENCER_TIMEOUT_EN
                    if (m_wl >= T) m_to = 1;
`endif
                end else begin
                    m_wl = 0;
                end
                case (m_phase)
                    P_WAIT_LOCK:  if (ls) begin m_phase = P_SETTLE; m_spent = 0; end
                    P_SETTLE:     begin m_spent++; if (m_spent == S) m_phase = P_WAIT_LOAD; end
                    P_WAIT_LOAD:  if (load) begin m_phase = P_HOLD_RESET; m_spent = 0; end
                    P_HOLD_RESET: begin m_spent++; if (m_spent == H) m_phase = P_SIGNAL; end
                    P_SIGNAL:     if (rv) begin m_phase = P_RUN; m_done = 1; end
                    default:      ;
                endcase
            end
        end
        #1;
    endtask

    task automatic wait_state(input int target, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (state === 3'(target)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; pll = 0; load = 0; rv = 0;
        model_reset();
        repeat (3) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL reset_core_reset_n got=%b exp=0", core_reset_n); end
        checks++; if (rtr_done !== 1'b0) begin errors++; $display("FAIL reset_rtr_done got=%b exp=0", rtr_done); end
        checks++; if (load_timeout !== 1'b0) begin errors++; $display("FAIL reset_load_timeout got=%b exp=0", load_timeout); end
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL idle_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
        end
    endtask

    task automatic test_nominal();
        int rise, pulses;
        load = 1; rv = 1; pll = 1; rise = -1; pulses = 0;
        for (int c = 1; c <= SEQ_LAT + 6; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL nominal_cycle c=%0d got=%b exp=%b", c, {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (rise < 0 && core_reset_n === 1'b1) rise = c;
            if (rtr_done === 1'b1) pulses++;
        end
        checks++; if (rise !== SEQ_LAT) begin errors++; $display("FAIL nominal_latency got=%0d exp=%0d", rise, SEQ_LAT); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL nominal_pulses got=%0d exp=1", pulses); end
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL nominal_run got=%0d exp=5", state); end
    endtask

    task automatic test_signal_wait();
        bit ok;
        int pulses;
        pll = 0; repeat (4) tick();
        load = 1; rv = 0; pll = 1;
        wait_state(P_SIGNAL, SEQ_LAT + 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sigwait_reach got=%0d exp=4", state); end
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL sigwait_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (rtr_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL sigwait_no_pulse got=%0d exp=0", pulses); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL sigwait_hold got=%0d exp=4", state); end
        rv = 1; tick();
        checks++; if (rtr_done !== 1'b1) begin errors++; $display("FAIL sigwait_pulse got=%b exp=1", rtr_done); end
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL sigwait_run got=%0d exp=5", state); end
        tick();
        checks++; if (rtr_done !== 1'b0) begin errors++; $display("FAIL sigwait_single got=%b exp=0", rtr_done); end
    endtask

    task automatic test_lock_loss();
        bit ok;
        int seen, rise, pulses;
        // Drop lock while in RUN.
        pll = 0; seen = -1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (seen < 0 && core_reset_n === 1'b0 && state === 3'd0) seen = c;
        end
        checks++; if (seen < 0) begin errors++; $display("FAIL lockloss_run got state=%0d rstn=%b exp state=0 rstn=0", state, core_reset_n); end
        // Drop lock while in HOLD_RESET.
        pll = 1; load = 1; rv = 1;
        wait_state(P_HOLD_RESET, SEQ_LAT, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lockloss_reach_hold got=%0d exp=3", state); end
        pll = 0; seen = -1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL lockloss_hold_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (seen < 0 && core_reset_n === 1'b0 && state === 3'd0) seen = c;
        end
        checks++; if (seen < 0) begin errors++; $display("FAIL lockloss_hold got state=%0d exp=0", state); end
        // Lock returns: full sequence with exactly one new acknowledge.
        pll = 1; rise = -1; pulses = 0;
        for (int c = 1; c <= SEQ_LAT + 4; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL relock_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (rise < 0 && core_reset_n === 1'b1) rise = c;
            if (rtr_done === 1'b1) pulses++;
        end
        checks++; if (rise !== SEQ_LAT) begin errors++; $display("FAIL relock_latency got=%0d exp=%0d", rise, SEQ_LAT); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL relock_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_in_settle();
        bit ok;
        int rise;
        pll = 0; repeat (4) tick();
        load = 1; rv = 1; pll = 1;
        wait_state(P_SETTLE, 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstsettle_reach got=%0d exp=1", state); end
        repeat (3) tick();
        #2 reset = 1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstsettle_state got=%0d exp=0", state); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL rstsettle_rstn got=%b exp=0", core_reset_n); end
        checks++; if (rtr_done !== 1'b0) begin errors++; $display("FAIL rstsettle_done got=%b exp=0", rtr_done); end
        model_reset();
        tick();
        reset = 0; rise = -1;
        for (int c = 1; c <= SEQ_LAT + 4; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL rstsettle_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (rise < 0 && core_reset_n === 1'b1) rise = c;
        end
        checks++; if (rise !== SEQ_LAT) begin errors++; $display("FAIL rstsettle_latency got=%0d exp=%0d", rise, SEQ_LAT); end
    endtask

    task automatic test_glitch();
        bit ok, saw_wl;
        int rise;
        pll = 0; repeat (4) tick();
        load = 1; rv = 1; pll = 1;
        wait_state(P_SETTLE, 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_reach got=%0d exp=1", state); end
        repeat (2) tick();
        pll = 0; tick(); pll = 1;
        saw_wl = 0; rise = -1;
        for (int c = 1; c <= SEQ_LAT + 4; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL glitch_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (state === 3'd0) saw_wl = 1;
            if (rise < 0 && core_reset_n === 1'b1) rise = c;
        end
        checks++; if (!saw_wl) begin errors++; $display("FAIL glitch_wait_lock got=0 exp=1"); end
        checks++; if (rise !== SEQ_LAT) begin errors++; $display("FAIL glitch_latency got=%0d exp=%0d", rise, SEQ_LAT); end
    endtask

`ifdef CORE_BOOT_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int k;
        pll = 0; repeat (4) tick();
        load = 0; rv = 1; pll = 1;
        wait_state(P_WAIT_LOAD, S + 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_reach got=%0d exp=2", state); end
        k = -1;
        for (int c = 1; c <= T + 5; c++) begin
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL timeout_cycle got=%b exp=%b", {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
            if (k < 0 && load_timeout === 1'b1) k = c;
        end
        checks++; if (k !== T) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", k, T); end
        load = 1;
        repeat (H + 4) tick();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL timeout_run got=%0d exp=5", state); end
        checks++; if (load_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", load_timeout); end
    endtask
`endif

    task automatic test_random();
        int low_left;
        low_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (reset) reset = 0;
            else if ($urandom_range(0, 399) == 0) reset = 1;
            if (low_left > 0) begin
                pll = 0; low_left--;
            end else begin
                pll = 1;
                if ($urandom_range(0, 79) == 0) low_left = $urandom_range(1, 4);
            end
            load = ($urandom_range(0, 3) == 0);
            rv   = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if ({state, core_reset_n, rtr_done, load_timeout} !== exp_vec()) begin
                errors++; $display("FAIL random_cycle c=%0d got=%b exp=%b", c, {state, core_reset_n, rtr_done, load_timeout}, exp_vec());
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_signal_wait();
        test_lock_loss();
        test_reset_in_settle();
        test_glitch();
`ifdef CORE_BOOT_SEQUENCER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
